// File: rtl/params_pkg.sv
// params_pkg: shared AXI widths, burst/response encodings and responder FSM states.
package params_pkg;

    localparam int AXI_ID_WIDTH   = 6;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_addr_next.sv
// axi_addr_next: combinational next-beat byte address for FIXED, INCR and WRAP bursts.
module axi_addr_next
    import params_pkg::*;
#(
    parameter int AW = AXI_ADDR_WIDTH
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] step;
    logic [AW-1:0] mask;
    logic [AW-1:0] incr;

    // WRAP keeps the upper bits of the aligned block and lets only the offset roll over
    always_comb begin
        step      = AW'(1) << size;
        mask      = ((AW'(len) + AW'(1)) << size) - AW'(1);
        incr      = addr + step;
        next_addr = (burst == INCR) ? incr :
                    (burst == WRAP) ? ((addr & ~mask) | (incr & mask)) : addr;
    end

endmodule

// File: rtl/axi_read_responder.sv
// axi_read_responder: single-outstanding AXI read slave serving bursts from a backdoor-loaded memory.
module axi_read_responder
    import params_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = AXI_ID_WIDTH,
    parameter int C_AXI_ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int C_AXI_DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int MEM_AW           = 10
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [C_AXI_ID_WIDTH-1:0]   ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                  ARLEN,
    input  logic [2:0]                  ARSIZE,
    input  logic [1:0]                  ARBURST,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   RID,
    output logic [C_AXI_DATA_WIDTH-1:0] RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        mem_we,
    input  logic [MEM_AW-1:0]           mem_waddr,
    input  logic [C_AXI_DATA_WIDTH-1:0] mem_wdata
);

    localparam int LSB = $clog2(C_AXI_DATA_WIDTH / 8);

    logic [C_AXI_DATA_WIDTH-1:0] mem [0:(2**MEM_AW)-1];

    state_e                      state_q, state_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic                        rlast_q, rlast_d;
    logic [C_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_e                       rresp_q, rresp_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                  len_q, len_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [2:0]                  size_q, size_d;
    logic [1:0]                  burst_q, burst_d;
    logic                        slverr_q, slverr_d;

    logic [C_AXI_ADDR_WIDTH-1:0] next_addr;
    logic [C_AXI_ADDR_WIDTH-1:0] beat_addr;
    logic                        beat_slv;
    logic                        beat_oob;
    resp_e                       beat_resp;
    logic                        load;

    axi_addr_next #(.AW(C_AXI_ADDR_WIDTH)) u_addr_next (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Backdoor port has no reset so preloaded contents survive ARESETn
    always_ff @(posedge ACLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        slverr_d  = slverr_q;
        load      = 1'b0;
        beat_addr = addr_q;
        beat_slv  = slverr_q;
        if (state_q == IDLE) begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
                state_d   = BURST;
                arready_d = 1'b0;
                rid_d     = ARID;
                addr_d    = ARADDR;
                len_d     = ARLEN;
                size_d    = ARSIZE;
                burst_d   = ARBURST;
                cnt_d     = '0;
                slverr_d  = (ARBURST == RSVD) || (32'(ARSIZE) > LSB) ||
                            ((ARBURST == WRAP) && !wrap_len_ok(ARLEN));
                beat_addr = ARADDR;
                beat_slv  = slverr_d;
                load      = 1'b1;
            end
        end else if (rvalid_q && RREADY) begin
            if (rlast_q) begin
                state_d   = IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end else begin
                addr_d    = next_addr;
                cnt_d     = cnt_q + 8'd1;
                beat_addr = next_addr;
                load      = 1'b1;
            end
        end
        beat_oob  = (beat_addr >> (LSB + MEM_AW)) != '0;
        beat_resp = beat_slv ? SLVERR : (beat_oob ? DECERR : OKAY);
        // Each beat is captured at load time so a later backdoor write cannot alter it
        if (load) begin
            rvalid_d = 1'b1;
            rlast_d  = (cnt_d == len_d);
            rresp_d  = beat_resp;
            rdata_d  = (beat_resp == OKAY) ? mem[beat_addr[LSB +: MEM_AW]] : '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            slverr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            slverr_q  <= slverr_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: directed bursts checked against a scoreboard of model-predicted beats.
module tb_axi_read_responder;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [5:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [5:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [5:0]  id;
    } beat_t;

    beat_t       sb [$];
    logic [31:0] mdl [0:1023];
    int          total = 0;
    int          fails = 0;

    always #5 ACLK = ~ACLK;

    axi_read_responder #(
        .C_AXI_ID_WIDTH(6), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .MEM_AW(10)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_waddr = 10'(idx);
        mem_wdata = d;
        @(negedge ACLK);
        mem_we    = 1'b0;
        mdl[idx]  = d;
    endtask

    function automatic void expect_burst(input logic [5:0] id, input logic [31:0] addr,
                                         input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        longint bytes, blk, base;
        bit     slv;
        bytes = longint'(1) << size;
        blk   = (longint'(len) + 1) * bytes;
        base  = (longint'(addr) / blk) * blk;
        slv   = (burst == 2'b11) || (size > 3'd2) ||
                ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a;
            beat_t       b;
            a = (burst == 2'b00) ? addr :
                (burst == 2'b10) ? 32'(base + (longint'(addr) - base + i * bytes) % blk) :
                                   32'(longint'(addr) + i * bytes);
            b.resp = slv ? 2'b10 : ((a >= 32'd4096) ? 2'b11 : 2'b00);
            b.data = (b.resp == 2'b00) ? mdl[a[11:2]] : 32'h0;
            b.last = (i == int'(len));
            b.id   = id;
            sb.push_back(b);
        end
    endfunction

    task automatic issue(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int w;
        expect_burst(id, addr, len, size, burst);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        w = 0;
        while (!ARREADY && w < 20) begin
            @(negedge ACLK);
            w++;
        end
        chk("arready_wait", 32'(ARREADY), 32'd1);
        @(posedge ACLK);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("first_beat_latency", 32'(RVALID), 32'd1);
        chk("arready_busy", 32'(ARREADY), 32'd0);
    endtask

    task automatic drain(input int n, input bit toggle);
        int          got, cyc;
        bit          stalled;
        logic [31:0] sd, sm;
        beat_t       e;
        got = 0; cyc = 0; stalled = 1'b0; sd = '0; sm = '0;
        while (got < n && cyc < 100) begin
            RREADY = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (stalled) begin
                chk("stall_rdata", RDATA, sd);
                chk("stall_ctrl", 32'({RVALID, RLAST, RRESP, RID}), sm);
            end
            stalled = 1'b0;
            if (!toggle) chk("back_to_back", 32'(RVALID), 32'd1);
            if (RVALID && RREADY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", RDATA, e.data);
                    chk("rresp", 32'(RRESP), 32'(e.resp));
                    chk("rlast", 32'(RLAST), 32'(e.last));
                    chk("rid", 32'(RID), 32'(e.id));
                end
                got++;
            end else if (RVALID) begin
                stalled = 1'b1;
                sd = RDATA;
                sm = 32'({RVALID, RLAST, RRESP, RID});
            end
            @(posedge ACLK);
            @(negedge ACLK);
            cyc++;
        end
        chk("beats_delivered", got, n);
        chk("idle_arready", 32'(ARREADY), 32'd1);
        chk("idle_rvalid", 32'(RVALID), 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge ACLK);
        chk("reset_arready", 32'(ARREADY), 32'd0);
        chk("reset_rvalid", 32'(RVALID), 32'd0);
        chk("reset_outputs", 32'({RLAST, RRESP, RID}) | RDATA, 32'd0);
        ARESETn = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("arready_after_reset", 32'(ARREADY), 32'd1);

        for (int i = 0; i < 4; i++) preload(i, 32'hA0 + 32'(i));
        for (int i = 4; i < 8; i++) preload(i, 32'h5EED_0000 + 32'(i));
        preload(1023, 32'hC0DE_03FF);

        // Plain INCR, back-to-back beats
        issue(6'd5, 32'h0, 8'd3, 3'd2, 2'b01);
        drain(4, 1'b0);

        // WRAP: words 2,3,0,1
        issue(6'd7, 32'h8, 8'd3, 3'd2, 2'b10);
        drain(4, 1'b0);

        // FIXED with RREADY toggling, outputs must hold while stalled
        issue(6'd9, 32'h4, 8'd2, 3'd2, 2'b00);
        drain(3, 1'b1);

        // Last word then out of range
        issue(6'd1, 32'hFFC, 8'd1, 3'd2, 2'b01);
        drain(2, 1'b0);

        // Illegal WRAP length, oversize beat, reserved burst with a single beat
        issue(6'd2, 32'h0, 8'd2, 3'd2, 2'b10);
        drain(3, 1'b0);
        issue(6'd3, 32'h0, 8'd1, 3'd3, 2'b01);
        drain(2, 1'b0);
        issue(6'd4, 32'h4, 8'd0, 3'd2, 2'b11);
        drain(1, 1'b1);

        // Address space wrap at 2**32: DECERR then word 0
        issue(6'd6, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
        drain(2, 1'b0);

        // Narrow byte beats crossing a word boundary
        issue(6'd8, 32'h1, 8'd3, 3'd0, 2'b01);
        drain(4, 1'b0);

        // Backdoor write while a beat is stalled: presented beat holds, next beat sees new data
        RREADY = 1'b0;
        issue(6'd10, 32'h0, 8'd1, 3'd2, 2'b01);
        mem_we = 1'b1; mem_waddr = 10'd0; mem_wdata = 32'hDEAD_0000;
        @(negedge ACLK);
        mem_waddr = 10'd1; mem_wdata = 32'hDEAD_0001;
        @(negedge ACLK);
        mem_we = 1'b0;
        mdl[0] = 32'hDEAD_0000;
        mdl[1] = 32'hDEAD_0001;
        chk("presented_beat_held", RDATA, 32'hA0);
        sb[1].data = 32'hDEAD_0001;
        drain(2, 1'b0);

        // Reset during the second beat of an 8-beat INCR
        RREADY = 1'b1;
        issue(6'd11, 32'h0, 8'd7, 3'd2, 2'b01);
        sb.delete();
        @(posedge ACLK);
        @(negedge ACLK);
        chk("beat2_before_reset", RDATA, mdl[1]);
        ARESETn = 1'b0;
        #1;
        chk("async_rvalid", 32'(RVALID), 32'd0);
        chk("async_arready", 32'(ARREADY), 32'd0);
        chk("async_outputs", 32'({RLAST, RRESP, RID}) | RDATA, 32'd0);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("no_beats_in_reset", 32'(RVALID), 32'd0);
        ARESETn = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("arready_after_release", 32'(ARREADY), 32'd1);
        chk("rvalid_after_release", 32'(RVALID), 32'd0);
        issue(6'd12, 32'h10, 8'd1, 3'd2, 2'b01);
        drain(2, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
